// File: rtl/cla_pipe_pkg.sv
// Shared types and helpers for the pipelined CLA adder: group geometry,
// per-stage control payload and the 4-bit carry-lookahead cell.
package cla_pipe_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    int ng;   // total 4-bit groups
    int gps;  // groups evaluated per stage
  } geom_t;

  typedef struct packed {
    logic sub;
    logic carry;      // carry into the next unevaluated group
    logic msb_carry;  // carry into the MSB, valid once the top group is done
    logic zero;
  } stage_ctl_t;

  typedef struct packed {
    logic [GROUP_W-1:0] s;
    logic               co;
    logic               c3;
  } cla4_t;

  function automatic geom_t calc_geom(input int width, input int stages);
    geom_t g;
    g.ng  = width / GROUP_W;
    g.gps = g.ng / stages;
    return g;
  endfunction

  function automatic cla4_t cla4(input logic [GROUP_W-1:0] a, input logic [GROUP_W-1:0] b,
                                 input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    cla4_t r;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    r.s  = p ^ c[3:0];
    r.co = c[4];
    r.c3 = c[3];
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_stage.sv
// One register stage of cla_pipe_add: evaluates GPS CLA groups, rippling carry
// group to group, and holds the beat. MSB-carry tap kept only with CLA_PIPE_OVF_EN.
module cla_pipe_stage
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_sum,
  input  stage_ctl_t       src_ctl,
  input  logic             adv,
  output logic             valid,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] psum,
  output stage_ctl_t       ctl
);

  localparam geom_t GEOM = calc_geom(WIDTH, STAGES);
  localparam int    GPS  = GEOM.gps;
  localparam int    SW   = GPS * GROUP_W;
  localparam int    LO   = IDX * SW;
  localparam bit    LAST = (IDX == STAGES - 1);

  logic [SW-1:0]    b_eff;
  logic [WIDTH-1:0] sum_d;
  logic             carry;
  logic             msb_c;
  logic             msb_d;
  logic             load;
  cla4_t            r;

  assign b_eff = src_ctl.sub ? ~src_b[LO +: SW] : src_b[LO +: SW];
  assign load  = !valid | adv;

  always_comb begin
    sum_d = src_sum;
    carry = src_ctl.carry;
    msb_c = 1'b0;
    r     = '0;
    for (int j = 0; j < GPS; j++) begin
      r = cla4(src_a[LO + j*GROUP_W +: GROUP_W], b_eff[j*GROUP_W +: GROUP_W], carry);
      sum_d[LO + j*GROUP_W +: GROUP_W] = r.s;
      msb_c = r.c3;
      carry = r.co;
    end
  end

`ifdef CLA_PIPE_OVF_EN
  assign msb_d = msb_c;
`else
  assign msb_d = 1'b0;
`endif

  // zero/msb fields arriving from upstream are recomputed here, never forwarded
  logic unused_in;
  assign unused_in = ^{msb_c, src_ctl.msb_carry, src_ctl.zero};

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      ctl   <= '0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        op_a          <= src_a;
        op_b          <= src_b;
        psum          <= sum_d;
        ctl.sub       <= src_ctl.sub;
        ctl.carry     <= carry;
        ctl.msb_carry <= msb_d;
        ctl.zero      <= LAST && (sum_d == '0);
      end
    end
  end

endmodule

// File: rtl/cla_pipe_add.sv
// Pipelined carry-lookahead adder/subtractor, STAGES register stages with
// valid/ready backpressure. Signed overflow flag enabled by CLA_PIPE_OVF_EN.
module cla_pipe_add
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  if (WIDTH % GROUP_W != 0) begin : g_bad_width
    $error("cla_pipe_add: WIDTH must be a multiple of 4");
  end
  if ((WIDTH / GROUP_W) % STAGES != 0) begin : g_bad_stages
    $error("cla_pipe_add: STAGES must divide WIDTH/4");
  end

  localparam int L = STAGES - 1;

  logic [STAGES-1:0]            v;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0][WIDTH-1:0] a_s, b_s, sum_s;
  stage_ctl_t [STAGES-1:0]      ctl_s;

  // A stage may advance when the next one is empty or itself advancing.
  always_comb begin
    adv    = '0;
    adv[L] = out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !v[k+1] | adv[k+1];
  end

  assign in_ready = !v[0] | adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_a, src_b, src_sum;
    stage_ctl_t       src_ctl;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_a     = a;
      assign src_b     = b;
      assign src_sum   = '0;
      assign src_ctl   = '{sub: sub, carry: sub | cin, msb_carry: 1'b0, zero: 1'b0};
    end else begin : g_link
      assign src_valid = v[k-1];
      assign src_a     = a_s[k-1];
      assign src_b     = b_s[k-1];
      assign src_sum   = sum_s[k-1];
      assign src_ctl   = ctl_s[k-1];
    end

    cla_pipe_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .IDX(k)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .src_valid(src_valid),
      .src_a    (src_a),
      .src_b    (src_b),
      .src_sum  (src_sum),
      .src_ctl  (src_ctl),
      .adv      (adv[k]),
      .valid    (v[k]),
      .op_a     (a_s[k]),
      .op_b     (b_s[k]),
      .psum     (sum_s[k]),
      .ctl      (ctl_s[k])
    );
  end

  assign out_valid = v[L];
  assign sum       = sum_s[L];
  assign cout      = ctl_s[L].carry;
  assign zero      = ctl_s[L].zero;

`ifdef CLA_PIPE_OVF_EN
  assign ovf = ctl_s[L].msb_carry ^ ctl_s[L].carry;
`else
  assign ovf = 1'b0;
`endif

  logic unused_tail;
  assign unused_tail = ^{a_s[L], b_s[L], ctl_s[L].sub, ctl_s[L].msb_carry};

endmodule
